// File: rtl/acc4_stream.sv
// acc4_stream: streams 4-bit operands through a single fadd4 ripple adder
// into a running accumulator. After NUM_OPS accepted operands it holds the
// sum and a sticky overflow flag until the downstream side consumes them.
// Optional build macro: ACC4_SAT_EN (the accumulator saturates at 4'hF on wrap
// instead of wrapping modulo 16).

// 4-bit ripple-carry adder, carry-out discarded.
module fadd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] r
);
  logic c1, c2, c3;

  assign c1 = a[0] & b[0];
  assign c2 = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign c3 = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));

  assign r[0] = a[0] ^ b[0];
  assign r[1] = a[1] ^ b[1] ^ c1;
  assign r[2] = a[2] ^ b[2] ^ c2;
  assign r[3] = a[3] ^ b[3] ^ c3;
endmodule

module acc4_stream #(
  parameter int unsigned NUM_OPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_ovf,
  output logic       busy
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(NUM_OPS);

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic [3:0] sum;
  logic       wrap;
  logic [3:0] acc_load;
  logic [3:0] cnt_inc;

  fadd4 u_fadd4 (
    .a (acc_q),
    .b (in_data),
    .r (sum)
  );

  // The adder has no carry-out, so a wrapped sum shows up as a result smaller
  // than the accumulator it started from.
  assign wrap    = (sum < acc_q);
  assign cnt_inc = cnt_q + 4'd1;

`ifdef ACC4_SAT_EN
  assign acc_load = wrap ? 4'hF : sum;
`else
  assign acc_load = sum;
`endif

  // State register; reset discards any partial accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: start in IDLE, one operand per cycle in ACCUM, hold result in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_load;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | wrap;
          if (cnt_inc == LAST_CNT) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_acc4_stream.sv
// Bench for acc4_stream: one instance with NUM_OPS=4 and one with NUM_OPS=1
// share clock, reset and data inputs but have separate start pulses. An
// integer-arithmetic model of each accumulation is compared against both
// instances every cycle, and directed scenarios add hand-computed checks.
module tb_acc4_stream;
  logic       clk;
  logic       rst;
  logic       start4, start1;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       ir4, ov4, oo4, bz4;
  logic [3:0] od4;
  logic       ir1, ov1, oo1, bz1;
  logic [3:0] od1;

  int tests;
  int fails;

  acc4_stream #(.NUM_OPS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (ir4),
    .out_valid (ov4),
    .out_ready (out_ready),
    .out_data  (od4),
    .out_ovf   (oo4),
    .busy      (bz4)
  );

  acc4_stream #(.NUM_OPS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (ir1),
    .out_valid (ov1),
    .out_ready (out_ready),
    .out_data  (od1),
    .out_ovf   (oo1),
    .busy      (bz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. phase: 0 waiting for start, 1 collecting, 2 result held.
  // total is kept as a plain integer and reduced per the accumulator rule.
  int  m_phase [2];
  int  m_taken [2];
  int  m_total [2];
  bit  m_ovf   [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      int  nops;
      bit  st;
      int  s;
      nops = (k == 0) ? 4 : 1;
      st   = (k == 0) ? start4 : start1;
      if (rst) begin
        m_phase[k] = 0;
        m_taken[k] = 0;
        m_total[k] = 0;
        m_ovf[k]   = 1'b0;
      end else if (m_phase[k] == 0) begin
        if (st) begin
          m_phase[k] = 1;
          m_taken[k] = 0;
          m_total[k] = 0;
          m_ovf[k]   = 1'b0;
        end
      end else if (m_phase[k] == 1) begin
        if (in_valid) begin
          s = m_total[k] + int'(in_data);
          if (s > 15) begin
            m_ovf[k] = 1'b1;
`ifdef ACC4_SAT_EN
            s = 15;
`else
            s = s - 16;
`endif
          end
          m_total[k] = s;
          m_taken[k] = m_taken[k] + 1;
          if (m_taken[k] == nops) m_phase[k] = 2;
        end
      end else begin
        if (out_ready) m_phase[k] = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("d4.in_ready",  int'(ir4), int'(m_phase[0] == 1));
    chk("d4.out_valid", int'(ov4), int'(m_phase[0] == 2));
    chk("d4.busy",      int'(bz4), int'(m_phase[0] != 0));
    chk("d4.out_data",  int'(od4), m_total[0]);
    if (m_phase[0] == 2) chk("d4.out_ovf", int'(oo4), int'(m_ovf[0]));
    chk("d1.in_ready",  int'(ir1), int'(m_phase[1] == 1));
    chk("d1.out_valid", int'(ov1), int'(m_phase[1] == 2));
    chk("d1.busy",      int'(bz1), int'(m_phase[1] != 0));
    chk("d1.out_data",  int'(od1), m_total[1]);
    if (m_phase[1] == 2) chk("d1.out_ovf", int'(oo1), int'(m_ovf[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic send(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic consume4();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume.out_valid", int'(ov4), 0);
    chk("consume.busy", int'(bz4), 0);
  endtask

  // Bounded wait for the NUM_OPS=4 result.
  task automatic wait_valid4(input string name);
    int n;
    n = 0;
    while (!ov4 && n < 20) begin
      tick();
      n++;
    end
    chk(name, int'(ov4), 1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    start4    = 1'b0;
    start1    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset.in_ready",  int'(ir4), 0);
    chk("reset.out_valid", int'(ov4), 0);
    chk("reset.out_data",  int'(od4), 0);
    chk("reset.out_ovf",   int'(oo4), 0);
    chk("reset.busy",      int'(bz4), 0);
    #3 rst = 1'b0;
    tick();

    // Basic sum 1+2+3+4 = 10; result visible one cycle after the 4th accept.
    pulse_start4();
    chk("basic.in_ready_after_start", int'(ir4), 1);
    chk("basic.busy_after_start", int'(bz4), 1);
    send(4'd1);
    send(4'd2);
    send(4'd3);
    chk("basic.not_yet_valid", int'(ov4), 0);
    send(4'd4);
    chk("basic.valid_latency5", int'(ov4), 1);
    chk("basic.in_ready_hold", int'(ir4), 0);
    chk("basic.out_data", int'(od4), 10);
    chk("basic.out_ovf", int'(oo4), 0);
    consume4();

    // Wrap: 8+8 overflows, then +1, +0.
    pulse_start4();
    send(4'd8);
    send(4'd8);
    send(4'd1);
    send(4'd0);
    wait_valid4("wrap.valid");
`ifdef ACC4_SAT_EN
    chk("wrap.out_data", int'(od4), 15);
`else
    chk("wrap.out_data", int'(od4), 1);
`endif
    chk("wrap.out_ovf", int'(oo4), 1);
    consume4();

    // Gaps between operands, then backpressure for 3 cycles.
    pulse_start4();
    send(4'd3);
    tick(); tick();
    send(4'd0);
    tick(); tick();
    send(4'd5);
    tick(); tick();
    send(4'd7);
    for (int i = 0; i < 3; i++) begin
      chk("bp.out_valid", int'(ov4), 1);
      chk("bp.out_data", int'(od4), 15);
      chk("bp.out_ovf", int'(oo4), 0);
      chk("bp.in_ready", int'(ir4), 0);
      tick();
    end
    consume4();

    // Start pulses during ACCUM and during HOLD are ignored.
    pulse_start4();
    send(4'd1);
    send(4'd1);
    pulse_start4();
    chk("ign.still_accum", int'(ir4), 1);
    send(4'd1);
    send(4'd1);
    chk("ign.out_data", int'(od4), 4);
    pulse_start4();
    chk("ign.hold_kept", int'(ov4), 1);
    chk("ign.hold_data", int'(od4), 4);
    consume4();
    tick();
    chk("ign.single_result", int'(ov4), 0);
    chk("ign.idle_after", int'(bz4), 0);

    // Asynchronous reset mid-accumulation after a wrap-free partial sum.
    pulse_start4();
    send(4'd2);
    send(4'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst.in_ready",  int'(ir4), 0);
    chk("arst.out_valid", int'(ov4), 0);
    chk("arst.out_data",  int'(od4), 0);
    chk("arst.out_ovf",   int'(oo4), 0);
    chk("arst.busy",      int'(bz4), 0);
    tick();
    #2 rst = 1'b0;
    tick();
    pulse_start4();
    send(4'd2);
    send(4'd2);
    send(4'd2);
    send(4'd2);
    chk("arst.fresh_valid", int'(ov4), 1);
    chk("arst.fresh_data", int'(od4), 8);
    chk("arst.fresh_ovf", int'(oo4), 0);
    consume4();

    // NUM_OPS=1 instance: a single operand completes the accumulation.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1.in_ready", int'(ir1), 1);
    send(4'd9);
    chk("n1.out_valid", int'(ov1), 1);
    chk("n1.out_data", int'(od1), 9);
    chk("n1.out_ovf", int'(oo1), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("n1.consumed", int'(ov1), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/acc4_stream.md
# acc4_stream

Sequential operand feeder and accumulator built around the team's 4-bit ripple adder `fadd4`. It accepts a stream of 4-bit operands over a valid/ready handshake and feeds the running total and each new operand into one internal `fadd4` instance (`a` = accumulator, `b` = operand). It registers the adder's `r` output back into the accumulator and, after `NUM_OPS` operands, presents the final sum downstream with a sticky overflow flag.

## Interface
- `NUM_OPS`, default 4: operands per accumulation; legal range 1..15.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins an accumulation; honoured only in IDLE.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 4: unsigned operand.
- `in_ready` output 1: block accepts an operand this cycle.
- `out_valid` output 1: `out_data`/`out_ovf` hold the final result.
- `out_ready` input 1: downstream consumes the result.
- `out_data` output 4: final accumulated sum.
- `out_ovf` output 1: at least one addition in this accumulation exceeded 4 bits.
- `busy` output 1: state is not IDLE.

## Operation
- Internal state: `acc[3:0]`, `cnt[3:0]`, sticky `ovf`, and a 2-bit FSM {IDLE, ACCUM, HOLD}.
- One `fadd4` instance: `a=acc`, `b=in_data`, `r` is the next sum. `fadd4` has no carry-out, so wrap is detected as `r < acc` (unsigned compare).
- IDLE:
  - `in_ready=0`, `out_valid=0`.
  - `start=1` clears `acc`, `cnt` and `ovf`, then moves to ACCUM.
- ACCUM:
  - `in_ready=1`.
  - Accept (`in_valid && in_ready` at the edge) sets `acc<=r` and `cnt<=cnt+1`, and sets `ovf` if `r<acc`.
  - If the accept makes `cnt` equal `NUM_OPS`, go to HOLD.
  - Cycles with `in_valid=0` leave all state unchanged.
- HOLD:
  - `in_ready=0`, `out_valid=1`, `out_data=acc`, `out_ovf=ovf`.
  - `out_ready=1` at the edge returns to IDLE.
  - Outputs stay stable while `out_ready=0`.
- `start` outside IDLE is ignored; it neither restarts nor queues.
- `start` and `in_valid` together in IDLE: only the start is taken. The operand is not accepted because `in_ready=0` in IDLE.
- `out_data` reads `acc` in every state; it is meaningful only while `out_valid=1`.
- Reset at any time, including mid-accumulation or in HOLD, forces IDLE, `acc=0`, `cnt=0`, `ovf=0`. Any partial accumulation is discarded.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=4'h0`, `out_ovf=0`, `busy=0`.
- `start` seen at edge T: `in_ready=1` and `busy=1` from T+1.
- Operand accept throughput is one per cycle. The combinational path is `fadd4` plus the compare, sampled the same cycle.
- Final accept at edge T: `out_valid=1` from T+1 and `in_ready=0` from T+1.
- Minimum latency from `start` to `out_valid` is `NUM_OPS+1` cycles.
- `out_valid && out_ready` at edge T: `out_valid=0` and `busy=0` from T+1. The earliest new `start` is sampled at T+1.
- All outputs are registered-state decodes; no input drives an output combinationally.

## Configuration
- `ACC4_SAT_EN` defined:
  - When `r<acc`, the accumulator loads `4'hF` instead of `r`.
  - Later additions start from 15, and any nonzero operand wraps again and re-saturates.
  - `ovf` is set exactly as in the default build.
- `ACC4_SAT_EN` undefined: the accumulator wraps modulo 16. This is the default.
- Handshake and timing are identical in both builds.

## Test plan
- Basic sum, `NUM_OPS=4`: reset, `start`, then operands 1,2,3,4 back-to-back -> `out_valid` one cycle after the 4th accept, `out_data=4'hA`, `out_ovf=0`, 5 cycles from start to valid.
- Wrap: operands 8,8,1,0 -> `out_data=4'h1`, `out_ovf=1`. With `ACC4_SAT_EN`: `out_data=4'hF`, `out_ovf=1`.
- Input gaps and backpressure: operands 3,0,5,7 with `in_valid` low for 2 cycles between each, then `out_ready` held low for 3 cycles -> `out_data=4'hF`, `out_ovf=0`. `out_valid` and `out_data` are stable and `in_ready=0` throughout the hold, and the block returns to IDLE the cycle after `out_ready=1`.
- Ignored start: pulse `start` after the 2nd operand of 1,1,1,1 -> accumulation is unaffected, `out_data=4'h4`. Pulse `start` during HOLD -> no effect, still one result.
- Reset mid-operation: assert `rst` asynchronously (between edges) after 2 of 4 operands -> all outputs read their reset values immediately. A fresh `start` with 2,2,2,2 then yields `out_data=4'h8`, `out_ovf=0`, showing no stale `cnt`/`ovf`.
- `NUM_OPS=1`: `start`, operand 9 -> `out_data=4'h9` one cycle after the accept.
